universal_shift_engine: RTL and testbench

Parametrised multi-mode shift engine, the successor to the team's basic load/shift register. It adds rotate, arithmetic and serial-fill modes, a serial output, and a counted multi-step shift run with a busy/done handshake. It sits between a controller that issues single start commands and datapath logic that consumes the parallel result or the serial bit stream.

---
 rtl/universal_shift_engine.sv | 111 +++++++++++
 tb/tb_universal_shift_engine.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/universal_shift_engine.sv
// Multi-mode shift engine: parallel load, counted shift/rotate/serial runs,
// serial output and a busy/done handshake around each run.
`timescale 1ns/1ps
module universal_shift_engine #(
  parameter int unsigned N  = 8,
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [N-1:0]  data_in,
  input  logic          start,
  input  logic [2:0]    mode,
  input  logic [CW-1:0] count,
  input  logic          sin,
  output logic [N-1:0]  q,
  output logic          sout,
  output logic          busy,
  output logic          done
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]    r_state, w_state_nxt;
  logic [N-1:0]  r_q, w_q_nxt, w_step_q;
  logic          r_sout, w_sout_nxt, w_step_sout;
  logic          r_busy, w_busy_nxt;
  logic          r_done, w_done_nxt;
  logic [2:0]    r_mode, w_mode_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;

  // One step of the latched mode applied to the current register value
  always_comb begin
    w_step_q    = r_q;
    w_step_sout = r_sout;
    case (r_mode)
      3'b000: begin w_step_q = {r_q[N-2:0], 1'b0};     w_step_sout = r_q[N-1]; end
      3'b001: begin w_step_q = {1'b0, r_q[N-1:1]};     w_step_sout = r_q[0];   end
      3'b010: begin w_step_q = {r_q[N-2:0], r_q[N-1]}; w_step_sout = r_q[N-1]; end
      3'b011: begin w_step_q = {r_q[0], r_q[N-1:1]};   w_step_sout = r_q[0];   end
      3'b100: begin w_step_q = {r_q[N-1], r_q[N-1:1]}; w_step_sout = r_q[0];   end
      3'b101: begin w_step_q = {r_q[N-2:0], sin};      w_step_sout = r_q[N-1]; end
      3'b110: begin w_step_q = {sin, r_q[N-1:1]};      w_step_sout = r_q[0];   end
      default: begin w_step_q = r_q;                   w_step_sout = r_sout;   end
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_sout_nxt  = r_sout;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_mode_nxt  = r_mode;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (load) begin
          w_q_nxt = data_in;
        end else if (start) begin
          if (count == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_mode_nxt  = mode;
            w_cnt_nxt   = count;
            w_busy_nxt  = 1'b1;
            w_state_nxt = S_RUN;
          end
        end
      end
      default: begin
        w_q_nxt    = w_step_q;
        w_sout_nxt = w_step_sout;
        w_cnt_nxt  = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_q     <= '0;
      r_sout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_mode  <= 3'b000;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_sout  <= w_sout_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_mode  <= w_mode_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign q    = r_q;
  assign sout = r_sout;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_universal_shift_engine.sv
// Bench for universal_shift_engine: arithmetic reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
`timescale 1ns/1ps
module tb_universal_shift_engine;

  logic       clk = 1'b0;
  logic       rst, load, start, sin;
  logic [7:0] data_in;
  logic [2:0] mode;
  logic [3:0] count;
  logic [7:0] q;
  logic       sout, busy, done;

  int n_tests = 0;
  int n_fail  = 0;
  bit en      = 1'b0;

  int m_q = 0, m_sout = 0, m_rem = 0, m_done = 0, m_mode = 0;

  universal_shift_engine #(.N(8), .CW(4)) dut (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in), .start(start),
    .mode(mode), .count(count), .sin(sin),
    .q(q), .sout(sout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  // Reference model: register value as an integer, run as steps remaining
  always @(posedge clk) begin
    if (rst) begin
      m_q = 0; m_sout = 0; m_rem = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (m_rem > 0) begin
        case (m_mode)
          0: begin m_sout = m_q / 128; m_q = (m_q * 2) % 256; end
          1: begin m_sout = m_q % 2;   m_q = m_q / 2; end
          2: begin m_sout = m_q / 128; m_q = (m_q * 2) % 256 + m_q / 128; end
          3: begin m_sout = m_q % 2;   m_q = m_q / 2 + (m_q % 2) * 128; end
          4: begin m_sout = m_q % 2;   m_q = m_q / 2 + ((m_q >= 128) ? 128 : 0); end
          5: begin m_sout = m_q / 128; m_q = (m_q * 2) % 256 + int'(sin); end
          6: begin m_sout = m_q % 2;   m_q = m_q / 2 + int'(sin) * 128; end
          default: ;
        endcase
        m_rem--;
        if (m_rem == 0) m_done = 1;
      end else if (load) begin
        m_q = int'(data_in);
      end else if (start) begin
        if (count == 4'd0) m_done = 1;
        else begin
          m_rem  = int'(count);
          m_mode = int'(mode);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (en) begin
      chk("cmp_q",    32'(q),    32'(m_q));
      chk("cmp_sout", 32'(sout), 32'(m_sout));
      chk("cmp_busy", 32'(busy), 32'(m_rem > 0));
      chk("cmp_done", 32'(done), 32'(m_done));
    end
  end

  task automatic do_load(input logic [7:0] v);
    load = 1'b1; start = 1'b0; data_in = v;
    step_clk();
    load = 1'b0;
  endtask

  // Issue a run, return busy-cycle count; leaves time in the done cycle
  task automatic do_run(input logic [2:0] md, input logic [3:0] cnt,
                        input logic [15:0] spat, input bit poke, output int bc);
    bit got_done;
    mode = md; count = cnt; start = 1'b1; load = 1'b0;
    step_clk();
    start = 1'b0; mode = 3'($urandom); count = 4'($urandom);
    bc = 0;
    got_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy) bc++;
      if (done) begin
        got_done = 1'b1;
        break;
      end
      sin = spat[i % 16];
      if (poke && i == 1) begin
        load = 1'b1; start = 1'b1; data_in = 8'($urandom);
      end else begin
        load = 1'b0; start = 1'b0;
      end
      step_clk();
    end
    load = 1'b0; start = 1'b0;
    chk("run_done_seen", 32'(got_done), 32'd1);
  endtask

  initial begin
    int bc;
    rst = 1'b1; load = 1'($urandom); start = 1'($urandom); sin = 1'($urandom);
    data_in = 8'($urandom); mode = 3'($urandom); count = 4'($urandom);
    step_clk();
    load = 1'($urandom); start = 1'($urandom); data_in = 8'($urandom);
    step_clk();
    en = 1'b1;
    chk("reset_q", 32'(q), 32'h00);
    chk("reset_sout", 32'(sout), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    rst = 1'b0; load = 1'b0; start = 1'b0;
    step_clk();

    // Logical left
    do_load(8'hB4);
    do_run(3'b000, 4'd3, 16'h0, 1'b0, bc);
    chk("lsl_busy_cycles", 32'(bc), 32'd3);
    chk("lsl_q", 32'(q), 32'hA0);
    chk("lsl_sout", 32'(sout), 32'd1);
    chk("lsl_done", 32'(done), 32'd1);
    chk("lsl_busy_low_at_done", 32'(busy), 32'd0);
    step_clk();
    chk("lsl_done_one_cycle", 32'(done), 32'd0);

    // Rotate right past the register width
    do_load(8'h81);
    do_run(3'b011, 4'd9, 16'h0, 1'b0, bc);
    chk("ror_q", 32'(q), 32'hC0);
    chk("ror_sout", 32'(sout), 32'd1);
    chk("ror_busy_cycles", 32'(bc), 32'd9);

    // Arithmetic right
    do_load(8'h90);
    do_run(3'b100, 4'd2, 16'h0, 1'b0, bc);
    chk("asr_q", 32'(q), 32'hE4);
    chk("asr_sout", 32'(sout), 32'd0);

    // Serial left, sin = 1,0,1,1
    do_load(8'h00);
    do_run(3'b101, 4'd4, 16'h000D, 1'b0, bc);
    chk("sl_q", 32'(q), 32'h0B);

    // Zero-count start
    do_load(8'h3C);
    do_run(3'b000, 4'd0, 16'h0, 1'b0, bc);
    chk("c0_busy_cycles", 32'(bc), 32'd0);
    chk("c0_q", 32'(q), 32'h3C);

    // Load/start pulsed mid-run must be ignored
    do_load(8'h0F);
    do_run(3'b010, 4'd6, 16'h0, 1'b1, bc);
    chk("poke_q", 32'(q), 32'hC3);
    chk("poke_busy_cycles", 32'(bc), 32'd6);

    // Load and start together: load wins, no run
    load = 1'b1; start = 1'b1; data_in = 8'h5A; mode = 3'b000; count = 4'd4;
    step_clk();
    load = 1'b0; start = 1'b0;
    chk("ls_q", 32'(q), 32'h5A);
    chk("ls_busy", 32'(busy), 32'd0);
    step_clk();
    chk("ls_no_done", 32'(done), 32'd0);
    chk("ls_still_idle", 32'(busy), 32'd0);

    // Hold mode
    do_load(8'h77);
    do_run(3'b111, 4'd5, 16'h0, 1'b0, bc);
    chk("hold_busy_cycles", 32'(bc), 32'd5);
    chk("hold_q", 32'(q), 32'h77);

    // Back-to-back runs: second start issued in the done cycle
    do_load(8'h01);
    do_run(3'b000, 4'd2, 16'h0, 1'b0, bc);
    chk("b2b_first_q", 32'(q), 32'h04);
    do_run(3'b000, 4'd3, 16'h0, 1'b0, bc);
    chk("b2b_second_q", 32'(q), 32'h20);
    chk("b2b_second_busy", 32'(bc), 32'd3);

    // Reset mid-run with 3 steps left
    do_load(8'hFF);
    mode = 3'b000; count = 4'd6; start = 1'b1;
    step_clk();
    start = 1'b0;
    repeat (3) step_clk();
    rst = 1'b1;
    step_clk();
    rst = 1'b0;
    chk("rst_run_q", 32'(q), 32'h00);
    chk("rst_run_busy", 32'(busy), 32'd0);
    bc = 0;
    repeat (6) begin
      step_clk();
      if (done) bc++;
    end
    chk("rst_run_no_done", 32'(bc), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst     = ($urandom_range(99) < 2);
      load    = ($urandom_range(99) < 15);
      start   = ($urandom_range(99) < 35);
      mode    = 3'($urandom);
      count   = ($urandom_range(3) == 0) ? 4'd0 : 4'($urandom);
      sin     = 1'($urandom);
      data_in = 8'($urandom);
      step_clk();
    end
    rst = 1'b0; load = 1'b0; start = 1'b0;
    step_clk();
    en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
